// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types for the uart_rx frame controller: FSM states, error codes, default marker.
package uart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CSUM    = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_OVERRUN = 3'd4
  } err_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_ctrl_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port, one combinational read port.
module uart_rx_frame_ctrl_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [DEPTH-1:0][7:0] mem;

  // Contents need no reset: a frame is only drained after all LEN bytes were written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind uart_rx: SYNC/LEN/payload/checksum parsing, buffered drain on a
// valid/ready port, rx-silence timeout and error reporting.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         MAX_LEN       = 32,
  parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_TICKS = 160,
  localparam int        LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       pl_data,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic             pl_last,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_done,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [7:0]       err_count
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len;
  logic [7:0]       sum;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_hit;
  err_t             err_kind;
  logic             len_bad, sum_ok, wr_last, rd_last;
  logic             tmo_active, tmo_hit, hs, buf_we;

  assign len_bad    = (rx_data == 8'd0) || (int'({24'd0, rx_data}) > MAX_LEN);
  assign sum_ok     = (sum + rx_data) == 8'd0;
  assign wr_last    = (LEN_W'(wr_ptr) == len - LEN_W'(1));
  assign rd_last    = (LEN_W'(rd_ptr) == len - LEN_W'(1));
  assign tmo_active = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  // A byte in the same cycle as the terminal tick keeps the frame alive.
  assign tmo_hit    = tmo_active && !rx_valid && clk_en &&
                      (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));
  assign hs         = pl_valid && pl_ready;
  assign buf_we     = (state == ST_PAYLOAD) && rx_valid;

  uart_rx_frame_ctrl_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (pl_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_hit   = 1'b0;
    err_kind  = ERR_NONE;
    case (state)
      ST_HUNT: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid) begin
          if (len_bad) begin
            err_hit   = 1'b1;
            err_kind  = ERR_LEN;
            state_nxt = ST_HUNT;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_hit   = 1'b1;
          err_kind  = ERR_TIMEOUT;
          state_nxt = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          if (wr_last) state_nxt = ST_CSUM;
        end else if (tmo_hit) begin
          err_hit   = 1'b1;
          err_kind  = ERR_TIMEOUT;
          state_nxt = ST_HUNT;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          if (sum_ok) begin
            state_nxt = ST_DRAIN;
          end else begin
            err_hit   = 1'b1;
            err_kind  = ERR_CSUM;
            state_nxt = ST_HUNT;
          end
        end else if (tmo_hit) begin
          err_hit   = 1'b1;
          err_kind  = ERR_TIMEOUT;
          state_nxt = ST_HUNT;
        end
      end
      ST_DRAIN: begin
        // Incoming bytes cannot be buffered while draining; they are flagged, not parsed.
        if (rx_valid) begin
          err_hit  = 1'b1;
          err_kind = ERR_OVERRUN;
        end
        if (hs && rd_last) state_nxt = ST_HUNT;
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    pl_valid   = (state == ST_DRAIN);
    pl_last    = pl_valid && rd_last;
    frame_done = pl_valid && pl_ready && rd_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tmo_cnt   <= '0;
      frame_len <= '0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      err_count <= '0;
    end else begin
      frame_err <= err_hit;
      if (err_hit) begin
        err_code <= err_kind;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      if (!tmo_active || rx_valid) tmo_cnt <= '0;
      else if (clk_en)             tmo_cnt <= tmo_cnt + TMO_W'(1);

      case (state)
        ST_LEN: begin
          if (rx_valid && !len_bad) begin
            len    <= rx_data[LEN_W-1:0];
            sum    <= rx_data;
            wr_ptr <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            sum    <= sum + rx_data;
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        ST_CSUM: begin
          if (rx_valid && sum_ok) begin
            rd_ptr    <= '0;
            frame_len <= len;
          end
        end
        ST_DRAIN: begin
          if (hs) rd_ptr <= rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed plus randomized frames against a frame-level model (payload queue, error tallies).
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 32;
  localparam int TMO     = 160;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clk_en = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic [7:0]       pl_data;
  logic             pl_valid;
  logic             pl_ready = 1'b1;
  logic             pl_last;
  logic [LEN_W-1:0] frame_len;
  logic             frame_done;
  logic             frame_err;
  logic [2:0]       err_code;
  logic [7:0]       err_count;

  uart_rx_frame_ctrl #(
    .MAX_LEN       (MAX_LEN),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_last    (pl_last),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: expected payload words {last, data}, error tallies, frame length.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int exp_code = 0, exp_cnt = 0, exp_pulses = 0, exp_done = 0, exp_flen = 0;
  int err_pulses = 0, done_cnt = 0;
  bit rdy_hold = 0, rdy_rand = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // clk_en: one tick every 4 clocks
  initial begin
    int div = 0;
    forever begin
      @(posedge clk); #1;
      div = (div + 1) % 4;
      clk_en = (div == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      pl_ready = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: handshakes, pulses, and stability of a stalled payload word.
  initial begin
    bit prev_stall = 0;
    logic [8:0] prev_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && pl_valid) chk("stall_hold", {23'd0, pl_last, pl_data}, {23'd0, prev_word});
        if (pl_valid && pl_ready) got_q.push_back({pl_last, pl_data});
        if (frame_done) done_cnt++;
        if (frame_err) err_pulses++;
        prev_stall = pl_valid && !pl_ready;
        prev_word  = {pl_last, pl_data};
      end
    end
  end

  task automatic model_err(input int code);
    exp_code = code;
    if (exp_cnt < 255) exp_cnt++;
    exp_pulses++;
  endtask

  // Frame-level rules: bad LEN, checksum over LEN..CSUM, else payload expected in order.
  task automatic model_frame(input logic [7:0] fb[$]);
    int l, s;
    l = int'(fb[1]);
    if (l == 0 || l > MAX_LEN) begin
      model_err(1);
    end else begin
      s = 0;
      for (int i = 1; i <= l + 2; i++) s += int'(fb[i]);
      if (s % 256 != 0) model_err(2);
      else begin
        for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), fb[2 + i]});
        exp_done++;
        exp_flen = l;
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    int t = 0;
    while (t < n) begin
      @(negedge clk);
      if (clk_en) t++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    wait_ticks(gap);
  endtask

  task automatic send_frame(input logic [7:0] fb[$], input int gap, input bit first_chk);
    for (int i = 0; i < fb.size() - 1; i++) send_byte(fb[i], gap);
    send_byte(fb[fb.size() - 1], 0);
    if (first_chk) begin
      chk("first_valid", {31'd0, pl_valid}, 32'd1);
      chk("first_data", {24'd0, pl_data}, {24'd0, fb[2]});
    end
    wait_ticks(gap);
  endtask

  task automatic check_frame(input string tag);
    int n = 0;
    while ((got_q.size() < exp_q.size() || pl_valid) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk({tag, "_drain_bound"}, {31'd0, (n < 5000)}, 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_err_pulses"}, err_pulses, exp_pulses);
    chk({tag, "_err_code"}, {29'd0, err_code}, exp_code);
    chk({tag, "_err_count"}, {24'd0, err_count}, exp_cnt);
    chk({tag, "_frame_len"}, {26'd0, frame_len}, exp_flen);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); got_q.delete();
    exp_code = 0; exp_cnt = 0; exp_pulses = 0; exp_done = 0; exp_flen = 0;
    err_pulses = 0; done_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pl_valid"}, {31'd0, pl_valid}, 0);
    chk({tag, "_pl_last"}, {31'd0, pl_last}, 0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 0);
    chk({tag, "_err_code"}, {29'd0, err_code}, 0);
    chk({tag, "_err_count"}, {24'd0, err_count}, 0);
    chk({tag, "_frame_len"}, {26'd0, frame_len}, 0);
  endtask

  initial begin
    logic [7:0] good[$];
    logic [7:0] fb[$];
    logic [7:0] b;
    int l, s, kind;

    good = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    do_reset();
    chk_reset_outputs("reset");

    // Good frame, full-rate consumer
    model_frame(good);
    send_frame(good, 80, 1);
    check_frame("good");

    // Bad checksum, then recovery
    fb = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    model_frame(fb);
    send_frame(fb, 80, 0);
    check_frame("bad_csum");
    model_frame(good);
    send_frame(good, 80, 0);
    check_frame("after_csum");

    // Junk in HUNT, LEN 0 and LEN MAX_LEN+1
    send_byte(8'h5A, 80);
    send_byte(8'h5A, 80);
    fb = {8'hA5, 8'h00};
    model_frame(fb); send_frame(fb, 80, 0);
    check_frame("len0");
    fb = {8'hA5, 8'h21};
    model_frame(fb); send_frame(fb, 80, 0);
    check_frame("len33");

    // Timeout boundary: 159 silent ticks survive, 160 abort
    model_frame(good);
    send_frame(good, TMO - 1, 0);
    check_frame("gap159");
    send_byte(8'hA5, 80);
    send_byte(8'h03, 80);
    send_byte(8'h11, 0);
    wait_ticks(TMO);
    model_err(3);
    check_frame("timeout");
    model_frame(good);
    send_frame(good, 80, 0);
    check_frame("after_tmo");

    // Overrun while stalled
    rdy_hold = 1;
    model_frame(good);
    send_frame(good, 80, 1);
    send_byte(8'h55, 0);
    model_err(4);
    repeat (20) @(negedge clk);
    chk("ovr_hold_data", {24'd0, pl_data}, 32'h11);
    chk("ovr_hold_valid", {31'd0, pl_valid}, 1);
    chk("ovr_code", {29'd0, err_code}, 4);
    rdy_hold = 0;
    check_frame("overrun");

    // Reset mid-frame
    send_byte(8'hA5, 80);
    send_byte(8'h03, 80);
    send_byte(8'h11, 10);
    do_reset();
    chk_reset_outputs("mid_reset");
    model_frame(good);
    send_frame(good, 80, 0);
    check_frame("after_rst");

    // Randomized frames with random backpressure
    rdy_rand = 1;
    for (int f = 0; f < 14; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b, 1);
      end
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        l = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        fb = {8'hA5, 8'(l)};
      end else begin
        l = (f == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
        fb = {8'hA5, 8'(l)};
        s = l;
        for (int i = 0; i < l; i++) begin
          b = 8'($urandom);
          fb.push_back(b);
          s += int'(b);
        end
        b = 8'(256 - (s % 256));
        if (kind == 1) b = b + 8'($urandom_range(1, 255));
        fb.push_back(b);
      end
      model_frame(fb);
      send_frame(fb, $urandom_range(1, 6), 0);
      check_frame("rand");
    end
    rdy_rand = 0;

    // err_count saturation
    for (int i = 0; i < 260; i++) begin
      fb = {8'hA5, 8'h00};
      model_frame(fb);
      send_frame(fb, 1, 0);
    end
    check_frame("saturate");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
